// File: rtl/sdram_port_sched.sv
// SDRAM port scheduler: ROM download writes, sprite 32-bit reads and
// round-robin main/sound CPU reads over a toggle req/ack SDRAM port.
module sdram_port_sched #(
    parameter int AW      = 23,
    parameter int TIMEOUT = 255
) (
    input  logic          clk_sd,
    input  logic          RESET,
    input  logic          dl_active,
    input  logic          dl_wr,
    input  logic [24:0]   dl_addr,
    input  logic [7:0]    dl_data,
    input  logic          m_req,
    input  logic [AW-1:0] m_addr,
    input  logic          s_req,
    input  logic [AW-1:0] s_addr,
    input  logic          sp_req,
    input  logic [AW-2:0] sp_addr,
    output logic [15:0]   m_q,
    output logic [15:0]   s_q,
    output logic [31:0]   sp_q,
    output logic          m_valid,
    output logic          s_valid,
    output logic          sp_valid,
    output logic          mem_req,
    input  logic          mem_ack,
    output logic [AW-1:0] mem_a,
    output logic          mem_we,
    output logic [1:0]    mem_ds,
    output logic [15:0]   mem_d,
    input  logic [15:0]   mem_q,
    output logic          busy,
    output logic          err_timeout,
    output logic          err_overrun
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_SP_HI
    } state_t;

    typedef enum logic [2:0] {
        GN_DL,
        GN_M,
        GN_S,
        GN_SPL,
        GN_SPH
    } gnt_t;

    state_t r_state;
    state_t w_state_nxt;
    gnt_t   r_gnt;
    gnt_t   w_gnt_nxt;

    logic          r_dl_wr_d;
    logic          r_dl_pend;
    logic [24:0]   r_dl_addr;
    logic [7:0]    r_dl_data;
    logic          r_last_snd;
    logic [AW-2:0] r_sp_addr;
    logic [CW-1:0] r_wcnt;

    logic          r_mem_req;
    logic [AW-1:0] r_mem_a;
    logic          r_mem_we;
    logic [1:0]    r_mem_ds;
    logic [15:0]   r_mem_d;
    logic [15:0]   r_m_q;
    logic [15:0]   r_s_q;
    logic [31:0]   r_sp_q;
    logic          r_m_valid;
    logic          r_s_valid;
    logic          r_sp_valid;
    logic          r_busy;
    logic          r_err_tmo;
    logic          r_err_ovr;

    logic          w_dl_rise;
    logic          w_acked;
    logic          w_tmo;
    logic          w_rd_ok;
    logic          w_sel_dl;
    logic          w_sel_sp;
    logic          w_sel_m;
    logic          w_sel_s;
    logic          w_any;
    logic          w_issue;
    logic          w_done;
    logic          w_abort;
    logic          w_take_dl;
    logic          w_busy_nxt;
    logic [AW-1:0] w_a;
    logic          w_we;
    logic [1:0]    w_ds;
    logic [15:0]   w_d;
    logic          w_unused;

    assign w_unused  = ^dl_addr;
    assign w_dl_rise = dl_wr & ~r_dl_wr_d;
    assign w_acked   = (mem_ack == r_mem_req);
    assign w_tmo     = (r_wcnt == CW'(TIMEOUT - 1));

    // Download bytes outrank everything; reads are frozen during download.
    assign w_rd_ok  = ~r_dl_pend & ~dl_active;
    assign w_sel_dl = r_dl_pend;
    assign w_sel_sp = w_rd_ok & sp_req;
    assign w_sel_m  = w_rd_ok & ~sp_req & m_req & (~s_req | r_last_snd);
    assign w_sel_s  = w_rd_ok & ~sp_req & s_req & ~w_sel_m;
    assign w_any    = w_sel_dl | w_sel_sp | w_sel_m | w_sel_s;

    always_ff @(posedge clk_sd) begin
        if (RESET) begin
            r_state <= ST_SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_SYNC: begin
                if (w_acked) w_state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (w_any) w_state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_acked) begin
                    if (r_gnt == GN_SPL) w_state_nxt = ST_SP_HI;
                    else w_state_nxt = ST_IDLE;
                end else if (w_tmo) begin
                    w_state_nxt = ST_SYNC;
                end
            end
            ST_SP_HI: begin
                w_state_nxt = ST_ISSUE;
            end
            default: w_state_nxt = ST_SYNC;
        endcase
    end

    always_comb begin
        w_issue    = 1'b0;
        w_done     = 1'b0;
        w_abort    = 1'b0;
        w_take_dl  = 1'b0;
        w_a        = '0;
        w_we       = 1'b0;
        w_ds       = 2'b00;
        w_d        = '0;
        w_gnt_nxt  = r_gnt;
        w_busy_nxt = (w_state_nxt != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                w_issue   = w_any;
                w_take_dl = w_sel_dl;
                unique case (1'b1)
                    w_sel_dl: begin
                        w_a       = r_dl_addr[AW:1];
                        w_we      = 1'b1;
                        w_ds      = {r_dl_addr[0], ~r_dl_addr[0]};
                        w_d       = {r_dl_data, r_dl_data};
                        w_gnt_nxt = GN_DL;
                    end
                    w_sel_sp: begin
                        w_a       = {sp_addr, 1'b0};
                        w_ds      = 2'b11;
                        w_gnt_nxt = GN_SPL;
                    end
                    w_sel_m: begin
                        w_a       = m_addr;
                        w_ds      = 2'b11;
                        w_gnt_nxt = GN_M;
                    end
                    w_sel_s: begin
                        w_a       = s_addr;
                        w_ds      = 2'b11;
                        w_gnt_nxt = GN_S;
                    end
                    default: ;
                endcase
            end
            ST_SP_HI: begin
                w_issue   = 1'b1;
                w_a       = {r_sp_addr, 1'b1};
                w_ds      = 2'b11;
                w_gnt_nxt = GN_SPH;
            end
            ST_WAIT: begin
                w_done  = w_acked;
                w_abort = ~w_acked & w_tmo;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_sd) begin
        if (RESET) begin
            r_gnt      <= GN_DL;
            r_dl_wr_d  <= 1'b0;
            r_dl_pend  <= 1'b0;
            r_dl_addr  <= '0;
            r_dl_data  <= '0;
            r_last_snd <= 1'b1;
            r_sp_addr  <= '0;
            r_wcnt     <= '0;
            r_mem_req  <= 1'b0;
            r_mem_a    <= '0;
            r_mem_we   <= 1'b0;
            r_mem_ds   <= 2'b00;
            r_mem_d    <= '0;
            r_m_q      <= '0;
            r_s_q      <= '0;
            r_sp_q     <= '0;
            r_m_valid  <= 1'b0;
            r_s_valid  <= 1'b0;
            r_sp_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_err_tmo  <= 1'b0;
            r_err_ovr  <= 1'b0;
        end else begin
            r_dl_wr_d  <= dl_wr;
            r_busy     <= w_busy_nxt;
            r_m_valid  <= 1'b0;
            r_s_valid  <= 1'b0;
            r_sp_valid <= 1'b0;
            if (w_issue) begin
                r_mem_req <= ~r_mem_req;
                r_wcnt    <= '0;
                r_mem_a   <= w_a;
                r_mem_we  <= w_we;
                r_mem_ds  <= w_ds;
                r_mem_d   <= w_d;
                r_gnt     <= w_gnt_nxt;
                if (w_take_dl) r_dl_pend <= 1'b0;
                if (r_state == ST_IDLE && w_sel_sp) r_sp_addr <= sp_addr;
            end else if (r_state == ST_ISSUE || r_state == ST_WAIT) begin
                r_wcnt <= r_wcnt + 1'b1;
            end
            if (w_done) begin
                case (r_gnt)
                    GN_M: begin
                        r_m_q      <= mem_q;
                        r_m_valid  <= ~dl_active;
                        r_last_snd <= 1'b0;
                    end
                    GN_S: begin
                        r_s_q      <= mem_q;
                        r_s_valid  <= ~dl_active;
                        r_last_snd <= 1'b1;
                    end
                    GN_SPL: r_sp_q[15:0] <= mem_q;
                    GN_SPH: begin
                        r_sp_q[31:16] <= mem_q;
                        r_sp_valid    <= ~dl_active;
                    end
                    default: ;
                endcase
            end
            if (w_abort) r_err_tmo <= 1'b1;
            // A new edge re-arms pending even if the old byte is granted now.
            if (w_dl_rise) begin
                r_dl_addr <= dl_addr;
                r_dl_data <= dl_data;
                r_dl_pend <= 1'b1;
                if (r_dl_pend & ~w_take_dl) r_err_ovr <= 1'b1;
            end
        end
    end

    assign m_q         = r_m_q;
    assign s_q         = r_s_q;
    assign sp_q        = r_sp_q;
    assign m_valid     = r_m_valid;
    assign s_valid     = r_s_valid;
    assign sp_valid    = r_sp_valid;
    assign mem_req     = r_mem_req;
    assign mem_a       = r_mem_a;
    assign mem_we      = r_mem_we;
    assign mem_ds      = r_mem_ds;
    assign mem_d       = r_mem_d;
    assign busy        = r_busy;
    assign err_timeout = r_err_tmo;
    assign err_overrun = r_err_ovr;

endmodule

// File: tb/tb_sdram_port_sched.sv
// Directed bench for sdram_port_sched with a toggle-handshake SDRAM
// responder that logs every issued access.
module tb_sdram_port_sched;

    localparam int AW = 23;

    logic          clk_sd = 1'b0;
    logic          RESET;
    logic          dl_active;
    logic          dl_wr;
    logic [24:0]   dl_addr;
    logic [7:0]    dl_data;
    logic          m_req;
    logic [AW-1:0] m_addr;
    logic          s_req;
    logic [AW-1:0] s_addr;
    logic          sp_req;
    logic [AW-2:0] sp_addr;
    logic [15:0]   m_q;
    logic [15:0]   s_q;
    logic [31:0]   sp_q;
    logic          m_valid;
    logic          s_valid;
    logic          sp_valid;
    logic          mem_req;
    logic          mem_ack;
    logic [AW-1:0] mem_a;
    logic          mem_we;
    logic [1:0]    mem_ds;
    logic [15:0]   mem_d;
    logic [15:0]   mem_q;
    logic          busy;
    logic          err_timeout;
    logic          err_overrun;

    always #5 clk_sd = ~clk_sd;

    sdram_port_sched #(.AW(AW), .TIMEOUT(255)) dut (
        .clk_sd(clk_sd), .RESET(RESET),
        .dl_active(dl_active), .dl_wr(dl_wr),
        .dl_addr(dl_addr), .dl_data(dl_data),
        .m_req(m_req), .m_addr(m_addr),
        .s_req(s_req), .s_addr(s_addr),
        .sp_req(sp_req), .sp_addr(sp_addr),
        .m_q(m_q), .s_q(s_q), .sp_q(sp_q),
        .m_valid(m_valid), .s_valid(s_valid), .sp_valid(sp_valid),
        .mem_req(mem_req), .mem_ack(mem_ack), .mem_a(mem_a),
        .mem_we(mem_we), .mem_ds(mem_ds), .mem_d(mem_d), .mem_q(mem_q),
        .busy(busy), .err_timeout(err_timeout), .err_overrun(err_overrun)
    );

    typedef struct {
        logic [AW-1:0] a;
        logic          we;
        logic [1:0]    ds;
        logic [15:0]   d;
        int            cyc;
    } acc_t;

    typedef struct {
        logic [24:0]   addr;
        logic [7:0]    data;
        logic [AW-1:0] ea;
        logic [1:0]    eds;
        logic [15:0]   ed;
    } dlv_t;

    int          errs = 0;
    int          checks = 0;
    int          cyc = 0;
    int          mv_n = 0;
    int          sv_n = 0;
    int          spv_n = 0;
    bit          ack_en = 1'b1;
    int          lat = 3;
    logic [15:0] rdq[$];
    acc_t        log_q[$];

    always @(posedge clk_sd) cyc++;

    always @(negedge clk_sd) begin
        if (m_valid) mv_n++;
        if (s_valid) sv_n++;
        if (sp_valid) spv_n++;
    end

    // SDRAM model: ack a toggle lat cycles later, return queued read data.
    initial begin
        logic prev_req;
        bit   rsp_pend;
        int   wcnt;
        prev_req = 1'b0;
        rsp_pend = 1'b0;
        wcnt = 0;
        mem_ack = 1'b0;
        mem_q = '0;
        forever begin
            @(posedge clk_sd);
            #1;
            if (RESET) begin
                prev_req = mem_req;
                rsp_pend = 1'b0;
                wcnt = 0;
            end else begin
                if (mem_req != prev_req) begin
                    prev_req = mem_req;
                    rsp_pend = 1'b1;
                    wcnt = 0;
                    log_q.push_back('{a: mem_a, we: mem_we, ds: mem_ds,
                                      d: mem_d, cyc: cyc});
                end
                if (ack_en && mem_req != mem_ack) begin
                    wcnt++;
                    if (wcnt >= lat) begin
                        mem_ack = mem_req;
                        if (rsp_pend && rdq.size() > 0) mem_q = rdq.pop_front();
                        rsp_pend = 1'b0;
                        wcnt = 0;
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    function automatic acc_t get_log(input int i);
        acc_t e;
        e = '{a: '0, we: 1'b0, ds: 2'b00, d: 16'h0, cyc: 0};
        if (i < log_q.size()) e = log_q[i];
        return e;
    endfunction

    function automatic logic vsig(input int w);
        case (w)
            0: return m_valid;
            1: return s_valid;
            default: return sp_valid;
        endcase
    endfunction

    task automatic wait_log(input int n, input int maxc, input string nm);
        int c = 0;
        while (log_q.size() < n && c < maxc) begin
            @(negedge clk_sd);
            c++;
        end
        chk(nm, 32'(log_q.size() >= n), 32'd1);
    endtask

    task automatic wait_valid(input int w, input int maxc, input string nm);
        int c = 0;
        do begin
            @(negedge clk_sd);
            c++;
        end while (!vsig(w) && c < maxc);
        chk(nm, 32'(vsig(w)), 32'd1);
    endtask

    task automatic wait_idle(input int maxc, input string nm);
        int c = 0;
        do begin
            @(negedge clk_sd);
            c++;
        end while (busy && c < maxc);
        chk(nm, 32'(busy), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        dlv_t        tv[5];
        acc_t        e;
        int          base;
        int          mv0;
        int          spv0;
        int          first;
        bit          seen_m;
        bit          seen_s;
        logic [15:0] gm;
        logic [15:0] gs;

        tv[0] = '{25'h0000003, 8'hA5, 23'h000001, 2'b10, 16'hA5A5};
        tv[1] = '{25'h0000000, 8'h3C, 23'h000000, 2'b01, 16'h3C3C};
        tv[2] = '{25'h0FFFFFF, 8'h5A, 23'h7FFFFF, 2'b10, 16'h5A5A};
        tv[3] = '{25'h1000000, 8'hFF, 23'h000000, 2'b01, 16'hFFFF};
        tv[4] = '{25'h0002468, 8'h7E, 23'h001234, 2'b01, 16'h7E7E};

        RESET = 1'b1;
        dl_active = 1'b0;
        dl_wr = 1'b0;
        dl_addr = '0;
        dl_data = '0;
        m_req = 1'b0;
        s_req = 1'b0;
        m_addr = '0;
        s_addr = '0;
        sp_req = 1'b0;
        sp_addr = '0;
        gm = '0;
        gs = '0;

        repeat (3) @(negedge clk_sd);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem", 32'({mem_req, mem_we, mem_ds, mem_d}), 32'd0);
        chk("rst_a", 32'(mem_a), 32'd0);
        chk("rst_q", 32'({m_q, s_q}), 32'd0);
        chk("rst_spq", sp_q, 32'd0);
        chk("rst_flags", 32'({m_valid, s_valid, sp_valid,
                              err_timeout, err_overrun}), 32'd0);
        RESET = 1'b0;
        repeat (2) @(negedge clk_sd);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_req", 32'(mem_req), 32'd0);

        // Download writes, with a main read held off by dl_active.
        dl_active = 1'b1;
        m_req = 1'b1;
        m_addr = 23'h000444;
        mv0 = mv_n;
        base = log_q.size();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_sd);
            dl_addr = tv[i].addr;
            dl_data = tv[i].data;
            dl_wr = 1'b1;
            @(negedge clk_sd);
            dl_wr = 1'b0;
            wait_log(base + i + 1, 10, "dl_toggle");
            e = get_log(base + i);
            chk("dl_a", 32'(e.a), 32'(tv[i].ea));
            chk("dl_we_ds", 32'({e.we, e.ds}), 32'({1'b1, tv[i].eds}));
            chk("dl_d", 32'(e.d), 32'(tv[i].ed));
            wait_idle(20, "dl_done");
        end
        repeat (4) @(negedge clk_sd);
        chk("dl_one_toggle_each", 32'(log_q.size() - base), 32'd5);
        chk("dl_no_read_valid", 32'(mv_n - mv0), 32'd0);
        m_req = 1'b0;
        dl_active = 1'b0;

        // Round robin from reset: main first, then sound.
        @(negedge clk_sd);
        RESET = 1'b1;
        m_req = 1'b1;
        s_req = 1'b1;
        m_addr = 23'h000100;
        s_addr = 23'h000200;
        lat = 3;
        rdq.push_back(16'h1111);
        rdq.push_back(16'h2222);
        repeat (2) @(negedge clk_sd);
        base = log_q.size();
        RESET = 1'b0;
        first = 0;
        seen_m = 1'b0;
        seen_s = 1'b0;
        for (int c = 0; c < 80 && !(seen_m && seen_s); c++) begin
            @(negedge clk_sd);
            if (m_valid && !seen_m) begin
                seen_m = 1'b1;
                gm = m_q;
                m_req = 1'b0;
                if (first == 0) first = 1;
            end
            if (s_valid && !seen_s) begin
                seen_s = 1'b1;
                gs = s_q;
                s_req = 1'b0;
                if (first == 0) first = 2;
            end
        end
        chk("rr_first_main", 32'(first), 32'd1);
        chk("rr_m_q", 32'(gm), 32'h1111);
        chk("rr_s_q", 32'(gs), 32'h2222);
        chk("rr_a0", 32'(get_log(base).a), 32'h100);
        chk("rr_a1", 32'(get_log(base + 1).a), 32'h200);
        chk("rr_rd_fields", 32'({get_log(base).we, get_log(base).ds}),
            32'b011);
        chk("rr_period", 32'((get_log(base + 1).cyc - get_log(base).cyc)
                              <= lat + 2), 32'd1);

        // Sprite 32-bit read.
        repeat (2) @(negedge clk_sd);
        rdq.push_back(16'hBEEF);
        rdq.push_back(16'hDEAD);
        base = log_q.size();
        spv0 = spv_n;
        sp_addr = 22'h0010;
        sp_req = 1'b1;
        wait_valid(2, 40, "sp_valid_seen");
        sp_req = 1'b0;
        chk("sp_q", sp_q, 32'hDEADBEEF);
        chk("sp_a_lo", 32'(get_log(base).a), 32'h20);
        chk("sp_a_hi", 32'(get_log(base + 1).a), 32'h21);
        chk("sp_hi_fields", 32'({get_log(base + 1).we,
                                 get_log(base + 1).ds}), 32'b011);
        repeat (5) @(negedge clk_sd);
        chk("sp_single_valid", 32'(spv_n - spv0), 32'd1);
        chk("sp_two_toggles", 32'(log_q.size() - base), 32'd2);

        // Two download edges during a sprite WAIT: first byte is lost.
        chk("ovr_clear_before", 32'(err_overrun), 32'd0);
        lat = 10;
        rdq.push_back(16'h0102);
        rdq.push_back(16'h0304);
        base = log_q.size();
        sp_addr = 22'h0040;
        sp_req = 1'b1;
        wait_log(base + 1, 10, "ovr_sp_issue");
        dl_addr = 25'h0000100;
        dl_data = 8'h11;
        dl_wr = 1'b1;
        @(negedge clk_sd);
        dl_wr = 1'b0;
        @(negedge clk_sd);
        dl_addr = 25'h0000203;
        dl_data = 8'h22;
        dl_wr = 1'b1;
        @(negedge clk_sd);
        dl_wr = 1'b0;
        chk("ovr_flag", 32'(err_overrun), 32'd1);
        wait_valid(2, 60, "ovr_sp_valid");
        sp_req = 1'b0;
        chk("ovr_sp_q", sp_q, 32'h03040102);
        wait_log(base + 3, 40, "ovr_write_issue");
        e = get_log(base + 2);
        chk("ovr_wr_a", 32'(e.a), 32'h101);
        chk("ovr_wr_we_ds", 32'({e.we, e.ds}), 32'b110);
        chk("ovr_wr_d", 32'(e.d), 32'h2222);
        wait_idle(30, "ovr_done");
        repeat (15) @(negedge clk_sd);
        chk("ovr_one_write", 32'(log_q.size() - base), 32'd3);

        // Timeout: ack withheld, abort 255 cycles after the toggle.
        ack_en = 1'b0;
        mv0 = mv_n;
        base = log_q.size();
        m_addr = 23'h000005;
        m_req = 1'b1;
        wait_log(base + 1, 10, "tmo_issue");
        for (int k = 1; k <= 255; k++) begin
            @(negedge clk_sd);
            if (k == 254) chk("tmo_not_yet", 32'(err_timeout), 32'd0);
            if (k == 255) chk("tmo_flag", 32'(err_timeout), 32'd1);
        end
        m_req = 1'b0;
        chk("tmo_in_sync_busy", 32'(busy), 32'd1);
        chk("tmo_no_valid", 32'(mv_n - mv0), 32'd0);
        ack_en = 1'b1;
        wait_idle(30, "tmo_resync");
        chk("tmo_no_reissue", 32'(log_q.size() - base), 32'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/sdram_port_sched.md
SDRAM_PORT_SCHED -- requirements
Module: sdram_port_sched

Interface
REQ-001 Parameter AW, default 23, word-address width of the SDRAM port (16-bit words).
REQ-002 Parameter TIMEOUT, default 255, maximum cycles to wait for mem_ack before an access is aborted.
REQ-003 Ports, listed as name direction width meaning:
- clk_sd  in  1  sole clock; all logic on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- dl_active  in  1  ROM download in progress.
- dl_wr  in  1  download byte strobe, level; a write is triggered on its rising edge.
- dl_addr  in  25  download byte address.
- dl_data  in  8  download byte.
- m_req, s_req  in  1  main-CPU / sound-CPU read request, level, held until the matching *_valid.
- m_addr, s_addr  in  AW  word addresses for main-CPU and sound-CPU reads.
- sp_req  in  1  sprite read request, level.
- sp_addr  in  AW-1  sprite 32-bit word address.
- m_q, s_q  out  16  read data for main and sound CPU.
- sp_q  out  32  sprite read data.
- m_valid, s_valid, sp_valid  out  1  one-cycle pulse; the matching q is valid in the same cycle.
- mem_req  out  1  toggle request to the SDRAM port.
- mem_ack  in  1  toggle acknowledge; the access is complete when mem_ack equals mem_req.
- mem_a  out  AW  SDRAM word address.
- mem_we  out  1  write enable.
- mem_ds  out  2  byte enables {hi, lo}.
- mem_d  out  16  write data.
- mem_q  in  16  read data, valid at the completion cycle.
- busy  out  1  high when the FSM is not in IDLE.
- err_timeout  out  1  sticky flag: an access was aborted on timeout.
- err_overrun  out  1  sticky flag: a download byte was lost.

Function
REQ-004 The FSM SHALL have the states SYNC, IDLE, ISSUE, WAIT, SP_HI.
REQ-005 SYNC SHALL move to IDLE on the first cycle in which mem_ack equals mem_req.
REQ-006 A rising edge on dl_wr (dl_wr high, previous-cycle dl_wr low) SHALL latch dl_addr and dl_data and set dl_pend.
REQ-007 An edge that arrives while dl_pend is still set SHALL overwrite the latched byte and set err_overrun.
REQ-008 In IDLE, the grant priority SHALL be: dl_pend first, then sp_req, then m_req/s_req; dl_pend is served regardless of dl_active.
REQ-009 m_req and s_req SHALL be served round-robin; the last-served pointer resets to "sound", so main wins the first tie.
REQ-010 While dl_active=1, read requests SHALL NOT be granted and no *_valid SHALL pulse.
REQ-011 On a grant, the FSM SHALL register mem_a, mem_we, mem_ds and mem_d, and toggle mem_req in the same cycle; the state becomes WAIT, passing through ISSUE for one cycle.
REQ-012 Download write fields:
- mem_a = dl_addr[AW:1]
- mem_we = 1
- mem_ds = {dl_addr[0], ~dl_addr[0]}
- mem_d = {dl_data, dl_data}
- dl_pend clears at the grant.
REQ-013 CPU read fields: mem_a = m_addr or s_addr, mem_we = 0, mem_ds = 2'b11.
REQ-014 Sprite low-half read SHALL use mem_a = {sp_addr, 1'b0}.
REQ-015 Read completion (WAIT with mem_ack == mem_req) SHALL register mem_q into the granted q, pulse the matching *_valid on the next cycle, and return to IDLE.
REQ-016 For a sprite access, completion of the low half SHALL store mem_q in sp_q[15:0] and enter SP_HI.
REQ-017 SP_HI SHALL issue mem_a = {sp_addr, 1'b1} with a new mem_req toggle.
REQ-018 On completion of the high half, mem_q SHALL go to sp_q[31:16] and sp_valid SHALL pulse once.
REQ-019 Write completion SHALL return to IDLE with no valid pulse.
REQ-020 A wait counter SHALL clear at every toggle and increment in WAIT.
REQ-021 When the wait counter reaches TIMEOUT:
- set err_timeout;
- drop the access with no valid pulse;
- go to SYNC.
REQ-022 A requester that drops its req before its valid pulse SHALL still have its access completed; its valid SHALL still pulse.
REQ-023 The round-robin pointer SHALL update only on the completion of a CPU read.
REQ-024 Throughput: with an ack latency of L cycles, back-to-back CPU reads SHALL complete at most every L+2 cycles.

Reset
REQ-025 RESET SHALL set the FSM to SYNC and clear mem_req, mem_we, mem_ds, mem_d, mem_a, all q outputs, all valid outputs, dl_pend, the dl_wr edge register, the wait counter, both error flags and busy, and set the round-robin pointer to "sound".
REQ-026 RESET asserted in WAIT or SP_HI SHALL abandon the access with no valid pulse.
REQ-027 After that RESET, the next request SHALL NOT issue until mem_ack equals mem_req.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- Reset release, mem_ack=0 → SYNC one cycle, then IDLE; busy=0, all outputs 0.
- dl_active=1, dl_wr edge with dl_addr=0x00003, dl_data=0xA5 → mem_a=1, mem_we=1, mem_ds=2'b10, mem_d=0xA5A5, one mem_req toggle.
- m_req and s_req both high from reset, ack latency 3, mem_q returns 0x1111 then 0x2222 → m_valid with m_q=0x1111, then s_valid with s_q=0x2222.
- sp_req, sp_addr=0x0010, mem_q 0xBEEF then 0xDEAD → mem_a 0x20 then 0x21; a single sp_valid with sp_q=0xDEADBEEF.
- mem_ack never toggles, TIMEOUT=255 → err_timeout set 255 cycles after the toggle; no valid; FSM back in SYNC.
- Two dl_wr edges, 2 cycles apart, while a sprite read is in WAIT → err_overrun=1; only the second byte is written after the sprite access completes.
